// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: register-file addressing with
// writeback bypass, control decode, load-use stall insertion and branch flush.
module id_ex_stage #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [31:0]            if_instr,
    input  logic                   if_valid,
    input  logic                   flush,
    output logic [4:0]             read_reg1,
    output logic [4:0]             read_reg2,
    input  logic [31:0]            read_data1,
    input  logic [31:0]            read_data2,
    input  logic                   wb_reg_write,
    input  logic [4:0]             wb_write_reg,
    input  logic [31:0]            wb_write_data,
    output logic                   stall,
    output logic                   ex_valid,
    output logic [31:0]            ex_rs_data,
    output logic [31:0]            ex_rt_data,
    output logic [31:0]            ex_imm,
    output logic [4:0]             ex_dest,
    output logic [2:0]             ex_alu_op,
    output logic                   ex_alu_src,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_mem_to_reg,
    output logic                   ex_branch,
    output logic                   illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned IMM_W = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'd4;

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    logic [OP_W-1:0]  opcode;
    logic [OP_W-1:0]  funct;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm_sext;
    logic             unused_shamt;

    assign opcode       = if_instr[31:26];
    assign rs           = if_instr[25:21];
    assign rt           = if_instr[20:16];
    assign rd           = if_instr[15:11];
    assign funct        = if_instr[5:0];
    assign imm_sext     = {{(XLEN-IMM_W){if_instr[IMM_W-1]}}, if_instr[IMM_W-1:0]};
    assign unused_shamt = ^if_instr[10:6];

    assign read_reg1 = rs;
    assign read_reg2 = rt;

    logic             dec_legal;
    logic [ALU_W-1:0] dec_alu_op;
    logic             dec_alu_src;
    logic             dec_reg_write;
    logic             dec_mem_read;
    logic             dec_mem_write;
    logic             dec_mem_to_reg;
    logic             dec_branch;
    logic [REG_W-1:0] dec_dest;
    logic             dec_use_rs;
    logic             dec_use_rt;

    // Control decode; unsupported encodings read no registers and never stall.
    always_comb begin
        dec_legal      = 1'b0;
        dec_alu_op     = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_dest       = rt;
        dec_use_rs     = 1'b0;
        dec_use_rt     = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_dest      = rd;
                dec_reg_write = 1'b1;
                dec_use_rs    = 1'b1;
                dec_use_rt    = 1'b1;
                dec_legal     = 1'b1;
                unique case (funct)
                    FN_ADD:  dec_alu_op = ALU_ADD;
                    FN_SUB:  dec_alu_op = ALU_SUB;
                    FN_AND:  dec_alu_op = ALU_AND;
                    FN_OR:   dec_alu_op = ALU_OR;
                    FN_SLT:  dec_alu_op = ALU_SLT;
                    default: begin
                        dec_legal     = 1'b0;
                        dec_reg_write = 1'b0;
                        dec_use_rs    = 1'b0;
                        dec_use_rt    = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                dec_legal      = 1'b1;
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_use_rs     = 1'b1;
            end
            OP_SW: begin
                dec_legal     = 1'b1;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_use_rs    = 1'b1;
                dec_use_rt    = 1'b1;
            end
            OP_BEQ: begin
                dec_legal  = 1'b1;
                dec_alu_op = ALU_SUB;
                dec_branch = 1'b1;
                dec_use_rs = 1'b1;
                dec_use_rt = 1'b1;
            end
            OP_ADDI: begin
                dec_legal     = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_use_rs    = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Writeback bypass covers the register file's write-then-read latency.
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            wb_fwd_ok;

    assign wb_fwd_ok = wb_reg_write && (wb_write_reg != REG_W'(0));
    assign operand_a = (wb_fwd_ok && (wb_write_reg == rs)) ? wb_write_data : read_data1;
    assign operand_b = (wb_fwd_ok && (wb_write_reg == rt)) ? wb_write_data : read_data2;

    logic hazard;
    logic load_en;

    assign hazard = if_valid && ex_valid && ex_mem_read && (ex_dest != REG_W'(0)) &&
                    ((dec_use_rs && (ex_dest == rs)) || (dec_use_rt && (ex_dest == rt)));
    assign stall   = hazard && !flush;
    assign load_en = if_valid && !flush && !stall && dec_legal;

    // ID/EX register; any non-load cycle inserts a bubble with all control cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid      <= 1'b0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_dest       <= '0;
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (load_en) begin
            ex_valid      <= 1'b1;
            ex_rs_data    <= operand_a;
            ex_rt_data    <= operand_b;
            ex_imm        <= imm_sext;
            ex_dest       <= dec_dest;
            ex_alu_op     <= dec_alu_op;
            ex_alu_src    <= dec_alu_src;
            ex_reg_write  <= dec_reg_write;
            ex_mem_read   <= dec_mem_read;
            ex_mem_write  <= dec_mem_write;
            ex_mem_to_reg <= dec_mem_to_reg;
            ex_branch     <= dec_branch;
        end else begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end
    end

    // Sticky illegal flag and saturating stall counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal     <= 1'b0;
            stall_count <= '0;
        end else begin
            if (if_valid && !flush && !dec_legal) begin
                illegal <= 1'b1;
            end
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized
// instruction streams against an instruction-level reference model.
module tb_id_ex_stage;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [31:0]   if_instr;
    logic          if_valid;
    logic          flush;
    logic [4:0]    read_reg1, read_reg2;
    logic [31:0]   read_data1, read_data2;
    logic          wb_reg_write;
    logic [4:0]    wb_write_reg;
    logic [31:0]   wb_write_data;
    logic          stall;
    logic          ex_valid;
    logic [31:0]   ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_dest;
    logic [2:0]    ex_alu_op;
    logic          ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic          illegal;
    logic [CW-1:0] stall_count;

    id_ex_stage #(.STALL_CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .if_instr(if_instr), .if_valid(if_valid),
        .flush(flush), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .stall(stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .illegal(illegal),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction meaning as listed in the ISA table.
    typedef struct packed {
        bit       ok;
        bit [2:0] alu;
        bit       src, rw, mr, mw, m2r, br, reads_rt;
        bit [4:0] dest;
    } dec_t;

    function automatic dec_t ref_dec(input bit [31:0] i);
        dec_t d;
        d = '0;
        d.dest = i[20:16];
        case (i[31:26])
            6'h00: begin
                d.dest = i[15:11];
                d.rw = 1; d.reads_rt = 1; d.ok = 1;
                case (i[5:0])
                    6'h20: d.alu = 0;
                    6'h22: d.alu = 1;
                    6'h24: d.alu = 2;
                    6'h25: d.alu = 3;
                    6'h2A: d.alu = 4;
                    default: d = '0;
                endcase
            end
            6'h23: begin d.ok = 1; d.src = 1; d.mr = 1; d.m2r = 1; d.rw = 1; end
            6'h2B: begin d.ok = 1; d.src = 1; d.mw = 1; d.reads_rt = 1; end
            6'h04: begin d.ok = 1; d.alu = 1; d.br = 1; d.reads_rt = 1; end
            6'h08: begin d.ok = 1; d.src = 1; d.rw = 1; end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic bit [31:0] rtype(input int rs, input int rt, input int rd, input bit [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic bit [31:0] itype(input bit [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Model of what EX holds.
    bit        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r, m_br, m_ill, m_stall;
    bit [2:0]  m_alu;
    bit [4:0]  m_dest;
    bit [31:0] m_a, m_b, m_imm;
    int        m_cnt;

    task automatic model_reset();
        m_valid = 0; m_src = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0;
        m_alu = 0; m_ill = 0; m_stall = 0; m_cnt = 0;
    endtask

    task automatic check_ex();
        check("ctrl", 32'({ex_valid, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
                           ex_mem_write, ex_mem_to_reg, ex_branch}),
                      32'({m_valid, m_alu, m_src, m_rw, m_mr, m_mw, m_m2r, m_br}));
        check("illegal", 32'(illegal), 32'(m_ill));
        check("stall_count", 32'(stall_count), 32'(m_cnt));
        if (m_valid) begin
            check("rs_data", ex_rs_data, m_a);
            check("rt_data", ex_rt_data, m_b);
            check("imm", ex_imm, m_imm);
            check("dest", 32'(ex_dest), 32'(m_dest));
        end
    endtask

    // One decode cycle: drive inputs, check combinational outputs, clock, check EX.
    task automatic cycle(input bit [31:0] ins, input bit v, input bit fl,
                         input bit [31:0] d1, input bit [31:0] d2,
                         input bit wbe, input bit [4:0] wr, input bit [31:0] wd);
        dec_t     d;
        bit [4:0] rs, rt;
        bit       hz;
        if_instr = ins; if_valid = v; flush = fl;
        read_data1 = d1; read_data2 = d2;
        wb_reg_write = wbe; wb_write_reg = wr; wb_write_data = wd;
        d  = ref_dec(ins);
        rs = ins[25:21];
        rt = ins[20:16];
        hz = v && d.ok && m_valid && m_mr && m_dest != 0 &&
             (m_dest == rs || (d.reads_rt && m_dest == rt));
        m_stall = hz && !fl;
        #1;
        check("read_reg1", 32'(read_reg1), 32'(rs));
        check("read_reg2", 32'(read_reg2), 32'(rt));
        check("stall", 32'(stall), 32'(m_stall));
        @(posedge clock);
        #1;
        if (m_stall && m_cnt < CMAX) m_cnt++;
        if (v && !fl && !d.ok) m_ill = 1;
        if (v && !fl && !m_stall && d.ok) begin
            m_valid = 1; m_alu = d.alu; m_src = d.src; m_rw = d.rw; m_mr = d.mr;
            m_mw = d.mw; m_m2r = d.m2r; m_br = d.br; m_dest = d.dest;
            m_a = (wbe && wr != 0 && wr == rs) ? wd : d1;
            m_b = (wbe && wr != 0 && wr == rt) ? wd : d2;
            m_imm = 32'($signed(ins[15:0]));
        end else begin
            m_valid = 0; m_alu = 0; m_src = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_br = 0;
        end
        check_ex();
    endtask

    task automatic simple(input bit [31:0] ins);
        cycle(ins, 1, 0, 32'h100, 32'h200, 0, 0, 0);
    endtask

    bit [31:0] r_ins;
    bit        r_v;

    initial begin
        reset_n = 0; if_instr = 0; if_valid = 0; flush = 0;
        read_data1 = 0; read_data2 = 0; wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_stall", 32'(stall), 0);
        check_ex();
        reset_n = 1;

        // R-type add $1,$21,$22
        cycle(32'h02B60820, 1, 0, 17, 29, 0, 0, 0);
        check("add_dest", 32'(ex_dest), 1);
        check("add_rs", ex_rs_data, 17);
        check("add_rt", ex_rt_data, 29);
        // lw $2,-4($3)
        simple(32'h8C62FFFC);
        check("lw_imm", ex_imm, 32'hFFFFFFFC);

        // Load-use: one stall, one bubble, then the add issues
        simple(itype(6'h23, 3, 2, 0));
        simple(rtype(2, 5, 4, 6'h20));
        check("lu_stall", 32'(m_stall), 1);
        simple(rtype(2, 5, 4, 6'h20));
        simple(rtype(0, 0, 0, 6'h20));
        check("lu_count", 32'(stall_count), 1);
        // addi writing $2 right after lw $2 does not read it
        simple(itype(6'h23, 3, 2, 0));
        simple(itype(6'h08, 5, 2, 1));

        // Same-cycle writeback bypass, and register 0 never bypassed
        cycle(rtype(21, 7, 8, 6'h20), 1, 0, 32'h99, 32'h77, 1, 21, 32'h1234);
        check("byp_rs", ex_rs_data, 32'h1234);
        cycle(rtype(0, 7, 8, 6'h20), 1, 0, 32'h55, 32'h77, 1, 0, 32'hDEAD);
        check("byp_r0", ex_rs_data, 32'h55);

        // Hazard coincident with flush
        simple(itype(6'h23, 3, 2, 0));
        cycle(rtype(2, 5, 4, 6'h20), 1, 1, 1, 2, 0, 0, 0);
        simple(rtype(2, 5, 4, 6'h22));

        // Illegal opcode is sticky
        simple(itype(6'h3F, 1, 2, 3));
        simple(rtype(1, 2, 3, 6'h25));
        check("ill_sticky", 32'(illegal), 1);

        // Repeated self-dependent loads drive the counter to saturation
        for (int i = 0; i < 40; i++) simple(itype(6'h23, 2, 2, 4));
        check("sat", 32'(stall_count), CMAX);

        // Reset in the middle of a stall
        simple(itype(6'h23, 3, 2, 0));
        if_instr = rtype(2, 5, 4, 6'h20);
        #1;
        check("pre_rst_stall", 32'(stall), 1);
        reset_n = 0;
        #1;
        model_reset();
        check("rst_stall_drop", 32'(stall), 0);
        check_ex();
        @(posedge clock);
        #1;
        reset_n = 1;
        cycle(rtype(2, 5, 4, 6'h20), 1, 0, 5, 6, 0, 0, 0);
        check("post_rst_load", 32'(ex_valid), 1);

        // Randomized streams; upstream holds the instruction while stalled
        r_ins = 0; r_v = 0;
        for (int n = 0; n < 600; n++) begin
            if (!m_stall) begin
                int k;
                int a, b, c;
                k = $urandom_range(0, 40);
                a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
                case (k % 10)
                    0, 1: begin
                        bit [5:0] fns [5];
                        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
                        r_ins = rtype(a, b, c, fns[$urandom_range(0, 4)]);
                    end
                    2, 3: r_ins = itype(6'h23, a, b, $urandom);
                    4:    r_ins = itype(6'h2B, a, b, $urandom);
                    5:    r_ins = itype(6'h04, a, b, $urandom);
                    default: r_ins = itype(6'h08, a, b, $urandom);
                endcase
                if (k == 40) r_ins = itype(6'h3F, a, b, 0);
                r_v = ($urandom_range(0, 9) != 0);
            end
            cycle(r_ins, r_v, ($urandom_range(0, 9) == 0), $urandom, $urandom,
                  1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
